// File: rtl/mt6835_read_scheduler_if.sv
// SPI angle-reader handshake between the read scheduler and the MT6835 reader.
// Signal names follow the scheduler's point of view (o_ = driven by scheduler).
interface mt6835_read_scheduler_if;
    logic        o_spi_start;
    logic        i_spi_ready;
    logic [15:0] i_spi_data;

    // Scheduler side
    modport master (
        output o_spi_start,
        input  i_spi_ready,
        input  i_spi_data
    );

    // Reader side
    modport slave (
        input  o_spi_start,
        output i_spi_ready,
        output i_spi_data
    );
endinterface

// File: rtl/mt6835_read_scheduler.sv
// MT6835 read scheduler: issues SPI read requests from a periodic timer or an
// external sync trigger, waits for the reader's ready edge, publishes the angle
// and a wrap-safe angle delta, and keeps timeout/overrun diagnostics.
module mt6835_read_scheduler #(
    parameter int unsigned PERIOD       = 5000,
    parameter int unsigned START_CYCLES = 10,
    parameter int unsigned TIMEOUT      = 2048
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic                            i_ext_trig,
    mt6835_read_scheduler_if.master         spi,
    output logic [15:0]                     o_angle,
    output logic [15:0]                     o_delta,
    output logic                            o_angle_valid,
    output logic                            o_delta_valid,
    output logic                            o_busy,
    output logic                            o_timeout_err,
    output logic [7:0]                      o_err_cnt,
    output logic [7:0]                      o_overrun_cnt
);

    localparam int unsigned SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT);

    localparam logic [15:0]     TIMER_LAST = 16'(PERIOD - 1);
    localparam logic [SC_W-1:0] START_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [15:0]     r_timer;
    logic [SC_W-1:0] r_start_cnt;
    logic [WD_W-1:0] r_wd;
    logic            r_pending;
    logic            r_ready_q;
    logic            r_have_prev;
    logic            r_spi_start;

    logic [15:0]     r_angle;
    logic [15:0]     r_delta;
    logic            r_angle_valid;
    logic            r_delta_valid;
    logic            r_timeout_err;
    logic [7:0]      r_err_cnt;
    logic [7:0]      r_overrun_cnt;

    logic            w_tick;
    logic            w_req;
    logic            w_rdy_rise;
    logic            w_launch;
    logic            w_done;
    logic            w_timeout;
    logic            w_overrun;

    assign w_tick     = i_enable && (r_timer == TIMER_LAST);
    assign w_req      = i_enable && (w_tick || i_ext_trig);
    assign w_rdy_rise = spi.i_spi_ready && !r_ready_q;
    assign w_overrun  = w_req && (r_state != S_IDLE);

    // Periodic timer: free-running 0..PERIOD-1 while enabled, parked at 0 otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable || (r_timer == TIMER_LAST)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // Ready edge detector history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ready_q <= 1'b0;
        end else begin
            r_ready_q <= spi.i_spi_ready;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and transaction strobes
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A pending request is only honoured while still enabled
                if (w_req || (r_pending && i_enable)) begin
                    w_state_next = S_START;
                    w_launch     = 1'b1;
                end
            end
            S_START: begin
                if (r_start_cnt == START_LAST) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_rdy_rise) begin
                    w_state_next = S_DONE;
                    w_done       = 1'b1;
                end else if (r_wd == WD_LAST) begin
                    w_state_next = S_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Start-pulse length counter and registered spi_start
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start_cnt <= '0;
            r_spi_start <= 1'b0;
        end else begin
            r_spi_start <= (w_state_next == S_START);
            if (r_state == S_START) begin
                r_start_cnt <= r_start_cnt + 1'b1;
            end else begin
                r_start_cnt <= '0;
            end
        end
    end

    // BUSY watchdog: zero on entry, counts every BUSY cycle without a ready edge
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != S_BUSY)) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Single-deep pending request and saturating overrun counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending     <= 1'b0;
            r_overrun_cnt <= '0;
        end else begin
            if (!i_enable) begin
                r_pending <= 1'b0;
            end else if (w_overrun) begin
                r_pending <= 1'b1;
            end else if (w_launch) begin
                r_pending <= 1'b0;
            end
            if (w_overrun && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
        end
    end

    // Result publication: angle/delta are captured on the BUSY->DONE edge so
    // they, and the angle_valid pulse, are presented during the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_angle       <= '0;
            r_delta       <= '0;
            r_angle_valid <= 1'b0;
            r_delta_valid <= 1'b0;
            r_have_prev   <= 1'b0;
        end else begin
            r_angle_valid <= w_done;
            if (w_done) begin
                r_angle       <= spi.i_spi_data;
                r_delta       <= r_have_prev ? (spi.i_spi_data - r_angle) : 16'd0;
                r_delta_valid <= r_have_prev;
                r_have_prev   <= 1'b1;
            end else if (w_timeout) begin
                r_delta_valid <= 1'b0;
                r_have_prev   <= 1'b0;
            end
        end
    end

    // Timeout pulse and saturating error counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timeout_err <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_timeout && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign spi.o_spi_start = r_spi_start;
    assign o_angle         = r_angle;
    assign o_delta         = r_delta;
    assign o_angle_valid   = r_angle_valid;
    assign o_delta_valid   = r_delta_valid;
    assign o_busy          = (r_state == S_START) || (r_state == S_BUSY);
    assign o_timeout_err   = r_timeout_err;
    assign o_err_cnt       = r_err_cnt;
    assign o_overrun_cnt   = r_overrun_cnt;

endmodule
